// File: rtl/ram_sdp_rd_stream.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : ram_sdp_rd_stream
// Purpose  : Read-side streaming adapter for a simple dual-port RAM. Read
//            addresses arrive on a valid/ready request stream and are issued
//            straight to the RAM read port. The RAM's fixed read latency
//            (1 or 2 cycles) is absorbed by an in-flight shift register and
//            a small return FIFO. Returned words leave on a valid/ready
//            output stream, in request order, with full backpressure.
//
// Ports    : clk          in   sole clock
//            rst_n        in   asynchronous active-low reset
//            req_valid    in   read request valid
//            req_ready    out  request accepted when req_valid && req_ready
//            req_addr     in   [ADDR_WIDTH] read address
//            ram_rd_en    out  RAM rd_en
//            ram_rd_addr  out  [ADDR_WIDTH] RAM rd_addr (= req_addr)
//            ram_rd_data  in   [DATA_WIDTH] RAM rd_data
//            out_valid    out  return data valid (buffer not empty)
//            out_ready    in   consumer ready; pop on out_valid && out_ready
//            out_data     out  [DATA_WIDTH] buffer head
//
// Revision : 1.0 - initial release
// ============================================================================
module ram_sdp_rd_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_ptr_w = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(BUF_DEPTH + 1);

    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(BUF_DEPTH - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(BUF_DEPTH);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $fatal(1, "ram_sdp_rd_stream: RD_LATENCY must be 1 or 2 (got %0d)", RD_LATENCY);
    end

    if (BUF_DEPTH < 2) begin : g_bad_depth
        $fatal(1, "ram_sdp_rd_stream: BUF_DEPTH must be >= 2 (got %0d)", BUF_DEPTH);
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [RD_LATENCY-1:0] inflight_q;
    logic [RD_LATENCY-1:0] inflight_d;
    logic [c_ptr_w-1:0]    wr_ptr_q;
    logic [c_ptr_w-1:0]    wr_ptr_d;
    logic [c_ptr_w-1:0]    rd_ptr_q;
    logic [c_ptr_w-1:0]    rd_ptr_d;
    logic [c_cnt_w-1:0]    occ_q;
    logic [c_cnt_w-1:0]    occ_d;
    logic [c_cnt_w-1:0]    used_q;
    logic [c_cnt_w-1:0]    used_d;
    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_d [BUF_DEPTH];

    logic w_accept;
    logic w_pop;
    logic w_arrive;

    // ------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------
    // `used` counts every read that has been accepted but not yet popped,
    // whether it is still inside the RAM or already buffered. Gating the
    // request side on it guarantees a buffer slot for every read in flight,
    // so arrivals never need to be refused. req_ready depends on a register
    // only, which keeps out_ready/req_valid off any combinational path to it.
    assign req_ready   = (used_q < c_depth);
    assign w_accept    = req_valid & req_ready;

    assign out_valid   = (occ_q != '0);
    assign w_pop       = out_valid & out_ready;
    assign out_data    = buf_q[rd_ptr_q];

    assign ram_rd_addr = req_addr;

    // The MSB of the in-flight register marks the cycle in which the RAM
    // presents the word for that read.
    assign w_arrive    = inflight_q[RD_LATENCY-1];

    // ------------------------------------------------------------------------
    // In-flight tracking and RAM read enable
    // ------------------------------------------------------------------------
    if (RD_LATENCY == 1) begin : g_lat_single
        assign inflight_d = w_accept;
        assign ram_rd_en  = w_accept;
    end else begin : g_lat_multi
        assign inflight_d = {inflight_q[RD_LATENCY-2:0], w_accept};
        // With the RAM output register enabled, rd_en also clocks that
        // register; keep it asserted while any read is still in an early
        // stage so its data is pushed through to rd_data. The address is
        // don't-care in such flush-only cycles.
        assign ram_rd_en  = w_accept | (|inflight_q[RD_LATENCY-2:0]);
    end

    // ------------------------------------------------------------------------
    // Pointer advance with wrap-around (depth need not be a power of two)
    // ------------------------------------------------------------------------
    function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_ptr_last) ? '0 : (ptr + c_ptr_one);
    endfunction

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        used_d   = used_q;

        if (w_arrive) begin
            buf_d[wr_ptr_q] = ram_rd_data;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end

        if (w_pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end

        // Buffer occupancy: arrival and pop in one cycle cancel out.
        case ({w_arrive, w_pop})
            2'b10:   occ_d = occ_q + c_cnt_one;
            2'b01:   occ_d = occ_q - c_cnt_one;
            default: occ_d = occ_q;
        endcase

        // Credits: accept and pop in one cycle cancel out.
        case ({w_accept, w_pop})
            2'b10:   used_d = used_q + c_cnt_one;
            2'b01:   used_d = used_q - c_cnt_one;
            default: used_d = used_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // Reset drops reads still inside the RAM: clearing inflight means any
    // word the RAM delivers after release is never written to the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            used_q     <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            used_q     <= used_d;
            buf_q      <= buf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_sdp_rd_stream.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : tb_ram_sdp_rd_stream
// Purpose  : Self-checking bench for ram_sdp_rd_stream. Several instances
//            with different RD_LATENCY / BUF_DEPTH run side by side, each
//            with its own behavioural RAM and a queue-based reference model
//            (expected word plus the cycle it becomes poppable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_sdp_rd_stream;

    localparam int N_CFG = 6;
    localparam int CFG_LAT   [N_CFG] = '{2, 1, 2, 1, 1, 2};
    localparam int CFG_DEPTH [N_CFG] = '{4, 2, 3, 8, 4, 8};

    typedef struct {
        logic [15:0] data;
        int          rdy;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    logic [N_CFG-1:0] all_done;

    task automatic chk(input int cfg, input string tag,
                       input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL cfg%0d %s: observed 0x%0h, expected 0x%0h", cfg, tag, obs, exp_v);
        end
    endtask

    for (genvar k = 0; k < N_CFG; k++) begin : g_cfg
        localparam int LAT   = CFG_LAT[k];
        localparam int DEPTH = CFG_DEPTH[k];

        logic        rst_n;
        logic        req_valid;
        logic        req_ready;
        logic [9:0]  req_addr;
        logic        ram_rd_en;
        logic [9:0]  ram_rd_addr;
        logic [15:0] ram_rd_data;
        logic [15:0] ram_s1;
        logic        out_valid;
        logic        out_ready;
        logic [15:0] out_data;
        logic        done = 1'b0;

        logic [15:0] mem [1024];
        exp_t        exp_q [$];
        int          cyc    = 0;
        int          n_acc  = 0;   // model accepts
        int          n_pop  = 0;   // model pops
        int          n_dacc = 0;   // DUT accepts
        int          n_dpop = 0;   // DUT pops
        logic        acc_prev = 1'b0;
        int          pv, pr, base_a, base_d;

        ram_sdp_rd_stream #(
            .DATA_WIDTH(16),
            .ADDR_WIDTH(10),
            .RD_LATENCY(LAT),
            .BUF_DEPTH (DEPTH)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid),
            .req_ready  (req_ready),
            .req_addr   (req_addr),
            .ram_rd_en  (ram_rd_en),
            .ram_rd_addr(ram_rd_addr),
            .ram_rd_data(ram_rd_data),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .out_data   (out_data)
        );

        assign all_done[k] = done;

        // Behavioural RAM read port: optional output register, both stages
        // advance only when rd_en is high.
        always @(posedge clk) begin
            if (ram_rd_en) begin
                ram_s1      <= mem[ram_rd_addr];
                ram_rd_data <= (LAT == 1) ? mem[ram_rd_addr] : ram_s1;
            end
        end

        // Reference model and per-cycle comparison, sampled mid-cycle.
        initial begin
            logic e_ready, e_valid, e_en;
            exp_t e;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    exp_q.delete();
                    acc_prev = 1'b0;
                    n_acc    = n_pop;
                    n_dacc   = n_dpop;
                end else begin
                    cyc++;
                    if (req_valid && req_ready) n_dacc++;
                    if (out_valid && out_ready) n_dpop++;
                    e_ready = (exp_q.size() < DEPTH);
                    e_valid = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
                    e_en    = (req_valid && e_ready) || ((LAT == 2) && acc_prev);
                    chk(k, "req_ready", 32'(req_ready), 32'(e_ready));
                    chk(k, "out_valid", 32'(out_valid), 32'(e_valid));
                    chk(k, "ram_rd_en", 32'(ram_rd_en), 32'(e_en));
                    if (e_valid && out_ready) begin
                        chk(k, "out_data", 32'(out_data), 32'(exp_q[0].data));
                        void'(exp_q.pop_front());
                        n_pop++;
                    end
                    if (req_valid && e_ready) begin
                        e.data = mem[req_addr];
                        e.rdy  = cyc + LAT + 1;
                        exp_q.push_back(e);
                        n_acc++;
                    end
                    acc_prev = req_valid && e_ready;
                end
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic drain(input string tag);
            out_ready = 1'b1;
            for (int g = 0; g < 300 && n_dpop != n_acc; g++) step();
            chk(k, tag, 32'(n_dpop), 32'(n_acc));
        endtask

        // Stimulus
        initial begin
            rst_n     = 1'b0;
            req_valid = 1'b0;
            out_ready = 1'b0;
            req_addr  = '0;
            for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
            repeat (3) @(posedge clk);
            #2;
            chk(k, "rst_out_valid", 32'(out_valid), 32'd0);
            chk(k, "rst_req_ready", 32'(req_ready), 32'd1);
            chk(k, "rst_out_data",  32'(out_data),  32'd0);
            chk(k, "rst_ram_rd_en", 32'(ram_rd_en), 32'd0);
            step();
            rst_n = 1'b1;

            // Single read of 0xBEEF
            mem[5]    = 16'hBEEF;
            out_ready = 1'b1;
            base_d    = n_dpop;
            req_valid = 1'b1;
            req_addr  = 10'd5;
            step();
            req_valid = 1'b0;
            repeat (LAT + 3) step();
            chk(k, "single_pops", 32'(n_dpop - base_d), 32'd1);

            // Streaming addr i holds i
            for (int i = 0; i < 64; i++) mem[i] = 16'(i);
            base_a = n_acc;
            base_d = n_dacc;
            for (int g = 0; g < 400 && (n_acc - base_a) < 64; g++) begin
                req_valid = 1'b1;
                req_addr  = 10'(n_acc - base_a);
                step();
            end
            req_valid = 1'b0;
            chk(k, "stream_acc", 32'(n_dacc - base_d), 32'd64);
            drain("stream_drain");

            // Backpressure: 10 offers with the output stalled
            out_ready = 1'b0;
            base_d    = n_dacc;
            for (int i = 0; i < 10; i++) begin
                req_valid = 1'b1;
                req_addr  = 10'($urandom);
                step();
            end
            chk(k, "bp_acc",   32'(n_dacc - base_d), 32'(DEPTH));
            chk(k, "bp_ready", 32'(req_ready), 32'd0);
            out_ready = 1'b1;
            for (int i = 0; i < 12; i++) begin
                req_valid = 1'b1;
                req_addr  = 10'($urandom);
                step();
            end
            req_valid = 1'b0;
            drain("bp_drain");

            // Reset with reads in flight and words buffered
            out_ready = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                req_valid = 1'b1;
                req_addr  = 10'($urandom);
                step();
            end
            req_valid = 1'b0;
            #1 rst_n = 1'b0;
            #1;
            chk(k, "mid_rst_out_valid", 32'(out_valid), 32'd0);
            chk(k, "mid_rst_req_ready", 32'(req_ready), 32'd1);
            chk(k, "mid_rst_out_data",  32'(out_data),  32'd0);
            repeat (2) step();
            rst_n     = 1'b1;
            out_ready = 1'b1;
            base_d    = n_dpop;
            req_valid = 1'b1;
            req_addr  = 10'd77;
            step();
            req_valid = 1'b0;
            repeat (LAT + 4) step();
            chk(k, "post_rst_pops", 32'(n_dpop - base_d), 32'd1);

            // Wrap-around with alternating out_ready
            base_a = n_acc;
            base_d = n_dacc;
            for (int g = 0; g < 400 && (n_acc - base_a) < 20; g++) begin
                req_valid = 1'b1;
                req_addr  = 10'($urandom);
                out_ready = ~out_ready;
                step();
            end
            req_valid = 1'b0;
            chk(k, "wrap_acc", 32'(n_dacc - base_d), 32'd20);
            drain("wrap_drain");

            // Random handshakes, 1000 accepted reads
            for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
            base_a = n_acc;
            base_d = n_dacc;
            pv = 60;
            pr = 60;
            for (int g = 0; g < 20000 && (n_acc - base_a) < 1000; g++) begin
                if (g % 64 == 0) begin
                    pv = $urandom_range(10, 100);
                    pr = $urandom_range(10, 100);
                end
                req_valid = ($urandom_range(0, 99) < pv);
                req_addr  = 10'($urandom);
                out_ready = ($urandom_range(0, 99) < pr);
                step();
            end
            req_valid = 1'b0;
            chk(k, "rand_acc", 32'(n_dacc - base_d), 32'd1000);
            drain("rand_drain");

            done = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 80000 && all_done !== {N_CFG{1'b1}}; i++) @(posedge clk);
        chk(N_CFG, "all_done", 32'(all_done), 32'({N_CFG{1'b1}}));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_sdp_rd_stream.md
# ram_sdp_rd_stream

Read-side streaming adapter for the simple dual-port RAM. It accepts read addresses on a valid/ready request stream and drives the RAM's read port. It absorbs the RAM's fixed read latency, which is 1 or 2 cycles depending on whether the RAM's output register is enabled. Returned data leaves on a valid/ready output stream with full backpressure, in request order, without loss. It sits directly on the RAM's `rd_en` / `rd_addr` / `rd_data` pins; the RAM's write port is untouched.

## Interface
- `DATA_WIDTH`, 16: RAM word width.
- `ADDR_WIDTH`, 10: RAM address width.
- `RD_LATENCY`, 2: RAM read latency in cycles. 1 means no RAM output register; 2 means RAM output register enabled. Any other value is a `$fatal` at elaboration.
- `BUF_DEPTH`, 4: return-buffer entries. `BUF_DEPTH` < 2 is a `$fatal` at elaboration. `BUF_DEPTH` ≥ `RD_LATENCY`+2 is required for one read per cycle sustained.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: read request valid.
- `req_ready` out 1: request accepted when `req_valid` && `req_ready`.
- `req_addr` in `ADDR_WIDTH`: read address.
- `ram_rd_en` out 1: to RAM `rd_en`.
- `ram_rd_addr` out `ADDR_WIDTH`: to RAM `rd_addr`.
- `ram_rd_data` in `DATA_WIDTH`: from RAM `rd_data`.
- `out_valid` out 1: return data valid.
- `out_ready` in 1: consumer ready; a pop occurs when `out_valid` && `out_ready`.
- `out_data` out `DATA_WIDTH`: return data, the buffer head.

## Operation
- **Accept / issue**
  - An accept issues the read in the same cycle.
  - `ram_rd_addr` = `req_addr`, passed through combinationally.
- **In-flight tracking**
  - `inflight` is an `RD_LATENCY`-bit valid shift register.
  - Bit 0 is set on accept; the register shifts every cycle.
  - Bit `RD_LATENCY`-1 set means `ram_rd_data` is valid this cycle.
- **`ram_rd_en` rule**
  - `ram_rd_en` = accept | OR of `inflight[RD_LATENCY-2:0]`.
  - For `RD_LATENCY`=1 it is accept only.
  - This keeps the RAM output register advancing while a read occupies its first stage. `ram_rd_addr` is don't-care in flush-only cycles.
- **Return buffer**
  - Circular register FIFO of `BUF_DEPTH` entries with wrap-around read and write pointers and occupancy counter `occ`.
  - The `ram_rd_data` word is written at the edge ending the cycle its `inflight` MSB is set.
- **Output**
  - `out_valid` = (`occ` != 0).
  - `out_data` = entry at the read pointer.
  - No bypass from `ram_rd_data` to `out_data`.
- **Credit counter `used`** (width `$clog2(BUF_DEPTH+1)`)
  - +1 on accept, −1 on pop, unchanged when both occur in the same cycle.
  - `req_ready` = (`used` < `BUF_DEPTH`).
  - `req_ready` is a function of registers only; there is no combinational path from `out_ready` or `req_valid`.
  - The buffer can therefore never overflow. An arrival is always accepted, even when `occ` = `BUF_DEPTH`−1 and a pop happens in the same cycle.
- **Ordering and occupancy**
  - Data returns strictly in request order. No reordering, no drops.
  - Arrival and pop in the same cycle: `occ` unchanged. Pop from `occ`=1 with no arrival: `out_valid` low next cycle.
- **Reset**
  - Asynchronous assert clears `inflight`, both pointers, `occ`, `used`, and buffer contents (0).
  - Outputs during and after reset: `out_valid`=0, `out_data`=0, `ram_rd_en`=0 (`req_valid` is low), `req_ready`=1.
  - Reset mid-operation discards in-flight reads. RAM data arriving after reset release is ignored.

## Timing
- Accept at cycle t:
  - `ram_rd_en`=1 at t.
  - For `RD_LATENCY`=2 only, `ram_rd_en`=1 also at t+1.
  - `ram_rd_data` is valid at t+`RD_LATENCY`.
  - Data is in the buffer and `out_valid`=1 at t+`RD_LATENCY`+1, the earliest pop cycle.
- Request-to-data latency is `RD_LATENCY`+1 cycles.
- Credit round trip is `RD_LATENCY`+2 cycles, which is why `BUF_DEPTH` ≥ `RD_LATENCY`+2 gives 1 read per cycle sustained.
- Back-to-back accepts pipeline fully; `ram_rd_en` stays high continuously.
- `out_ready` low stalls the output only. Reads already issued still land in the buffer. `req_ready` drops once `used` reaches `BUF_DEPTH`.

## Test plan
- **Single read:** RAM preloaded with addr 5 = 0xBEEF, `RD_LATENCY`=2, one request to addr 5 at cycle 10, `out_ready`=1 → `ram_rd_en` high in cycles 10–11; `out_valid`=1 with `out_data`=0xBEEF in cycle 13 only.
- **Streaming:** RAM addr i = i, 64 back-to-back requests to addr 0..63, `out_ready`=1, `BUF_DEPTH`=4 → `req_ready` never drops; 64 outputs 0..63 in order on consecutive cycles.
- **Backpressure / full:** `out_ready`=0, 10 requests offered → exactly 4 accepted, `req_ready`=0 thereafter. Raise `out_ready` → 4 words in order, and each pop re-enables one accept.
- **Random handshakes:** 1000 random addresses with random `req_valid` / `out_ready` patterns, for both `RD_LATENCY` = 1 and 2, `BUF_DEPTH` ∈ {2, 3, 4, 8} → scoreboard matches every word in order; no overflow, no drop; at most 1 accept per cycle.
- **Reset mid-flight:** `rst_n` asserted with 2 reads in flight and 2 words buffered → `out_valid`=0 and `req_ready`=1 immediately. After release, the next request returns only its own data; no stale words.
- **Wrap-around:** `BUF_DEPTH`=3, 20 requests with alternating `out_ready` → pointers wrap at least 6 times, data stays in order, `occ` never exceeds 3.
